// File: rtl/ms_pkg.sv
// Shared minesweeper definitions: board geometry, controller states and
// the cell index / one-hot helpers used by the input front end and the datapath.
package ms_pkg;

    localparam int GRID_DIM = 5;
    localparam int NCELLS   = GRID_DIM * GRID_DIM;
    localparam int IDX_W    = 5;
    localparam int COORD_W  = 3;

    // Bit positions of the buttons inside the packed button vector
    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_SEL   = 4;
    localparam int NBTN      = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_ACK,
        LOCKED
    } state_t;

    // Linear cell index row*GRID_DIM+col; stays within 0..NCELLS-1 for legal coordinates
    function automatic logic [IDX_W-1:0] idx_of(input logic [COORD_W-1:0] row,
                                                input logic [COORD_W-1:0] col);
        logic [IDX_W-1:0] r;
        r = IDX_W'(row);
        return r * IDX_W'(GRID_DIM) + IDX_W'(col);
    endfunction

    // One-hot cell vector with only bit idx set
    function automatic logic [NCELLS-1:0] onehot_of(input logic [IDX_W-1:0] idx);
        return NCELLS'(1) << idx;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single push-button conditioner: 2-flop synchronizer, consecutive-sample
// debounce counter and a one-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int DEBOUNCE = 16
) (
    input  logic clka,
    input  logic restart,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE + 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clka domain
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Count disagreeing samples; flip the level on the DEBOUNCE-th one, clear on any agreeing sample
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (sync2 == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE - 1)) begin
            cnt   <= '0;
            level <= sync2;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Registered one-cycle pulse on each debounced rising edge
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end

endmodule

// File: rtl/cell_select_encoder.sv
// Minesweeper user-input front end: debounced buttons move a cursor over the
// board, a select offers the cursor's cell index to the controller over req/ack.
module cell_select_encoder #(
    parameter int DEBOUNCE = 16,
    parameter int GRID_DIM = ms_pkg::GRID_DIM
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_sel,
    input  logic [24:0] cleared,
    input  logic        gameover,
    input  logic        ack,
    output logic [4:0]  data,
    output logic        req,
    output logic [24:0] cursor_onehot,
    output logic        reject
);

    import ms_pkg::*;

    localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(GRID_DIM - 1);

    state_t             state;
    state_t             state_next;
    logic [COORD_W-1:0] row;
    logic [COORD_W-1:0] col;
    logic [IDX_W-1:0]   cur_idx;
    logic               sel_hit;

    logic [NBTN-1:0]    raw_btn;
    logic [NBTN-1:0]    lvl;
    logic [NBTN-1:0]    prs;
    logic [NBTN-1:0]    act;

    logic               do_sel;
    logic               do_up;
    logic               do_down;
    logic               do_left;
    logic               do_right;

    assign raw_btn[BTN_RIGHT] = btn_right;
    assign raw_btn[BTN_LEFT]  = btn_left;
    assign raw_btn[BTN_DOWN]  = btn_down;
    assign raw_btn[BTN_UP]    = btn_up;
    assign raw_btn[BTN_SEL]   = btn_sel;

    for (genvar b = 0; b < NBTN; b++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_debounce (
            .clka   (clka),
            .restart(restart),
            .raw    (raw_btn[b]),
            .level  (lvl[b]),
            .press  (prs[b])
        );
    end

    // A press is only honoured while its debounced level is still asserted
    assign act     = prs & lvl;
    assign cur_idx = idx_of(row, col);
    assign sel_hit = cleared[cur_idx];

    // Fixed-priority arbitration: sel > up > down > left > right, only in IDLE outside game over
    always_comb begin
        do_sel   = 1'b0;
        do_up    = 1'b0;
        do_down  = 1'b0;
        do_left  = 1'b0;
        do_right = 1'b0;
        if (state == IDLE && !gameover) begin
            if (act[BTN_SEL])        do_sel   = 1'b1;
            else if (act[BTN_UP])    do_up    = 1'b1;
            else if (act[BTN_DOWN])  do_down  = 1'b1;
            else if (act[BTN_LEFT])  do_left  = 1'b1;
            else if (act[BTN_RIGHT]) do_right = 1'b1;
        end
    end

    // Controller state register
    always_ff @(posedge clka or posedge restart) begin
        if (restart) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state logic; game over overrides ack and select
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (gameover)                 state_next = LOCKED;
                else if (do_sel && !sel_hit)  state_next = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (gameover)                 state_next = LOCKED;
                else if (ack)                 state_next = IDLE;
            end
            LOCKED: begin
                if (!gameover)                state_next = IDLE;
            end
            default:                          state_next = IDLE;
        endcase
    end

    // Outputs decoded from state and cursor registers
    always_comb begin
        req           = (state == WAIT_ACK);
        cursor_onehot = onehot_of(cur_idx);
    end

    // Cursor, captured index and reject pulse, with wrap-around at the board edges
    always_ff @(posedge clka or posedge restart) begin
        if (restart) begin
            row    <= '0;
            col    <= '0;
            data   <= '0;
            reject <= 1'b0;
        end else begin
            reject <= do_sel && sel_hit;
            if (do_sel && !sel_hit) data <= cur_idx;
            if (do_up)    row <= (row == '0)        ? COORD_MAX : row - 1'b1;
            if (do_down)  row <= (row == COORD_MAX) ? '0        : row + 1'b1;
            if (do_left)  col <= (col == '0)        ? COORD_MAX : col - 1'b1;
            if (do_right) col <= (col == COORD_MAX) ? '0        : col + 1'b1;
        end
    end

endmodule

// File: tb/tb_cell_select_encoder.sv
// Scoreboard bench for cell_select_encoder: stimulus queues the expected
// output events with their exact clka edge, a monitor pops and compares them.
module tb_cell_select_encoder;

    localparam int D = 4;

    localparam logic [4:0] M_RIGHT = 5'b00001;
    localparam logic [4:0] M_LEFT  = 5'b00010;
    localparam logic [4:0] M_DOWN  = 5'b00100;
    localparam logic [4:0] M_UP    = 5'b01000;
    localparam logic [4:0] M_SEL   = 5'b10000;

    localparam int K_NONE    = -1;
    localparam int K_MOVE    = 0;
    localparam int K_REQ     = 1;
    localparam int K_DROP    = 2;
    localparam int K_REJ     = 3;
    localparam int K_REJ_END = 4;
    localparam int K_DATA    = 5;

    logic        clka = 1'b0;
    logic        restart = 1'b1;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_sel = 1'b0;
    logic [24:0] cleared = '0;
    logic        gameover = 1'b0;
    logic        ack = 1'b0;
    logic [4:0]  data;
    logic        req;
    logic [24:0] cursor_onehot;
    logic        reject;

    cell_select_encoder #(
        .DEBOUNCE(D),
        .GRID_DIM(5)
    ) dut (
        .clka         (clka),
        .restart      (restart),
        .btn_up       (btn_up),
        .btn_down     (btn_down),
        .btn_left     (btn_left),
        .btn_right    (btn_right),
        .btn_sel      (btn_sel),
        .cleared      (cleared),
        .gameover     (gameover),
        .ack          (ack),
        .data         (data),
        .req          (req),
        .cursor_onehot(cursor_onehot),
        .reject       (reject)
    );

    always #5 clka = ~clka;

    int cyc = 0;
    always @(posedge clka) cyc <= cyc + 1;

    typedef struct {
        int kind;
        int value;
        int at;
    } ev_t;

    ev_t   expq[$];
    int    checks = 0;
    int    passed = 0;
    bit    in_reset = 1'b1;
    string kname [0:5] = '{"move", "req_rise", "req_drop", "reject_rise", "reject_fall", "data_change"};

    task automatic chk(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passed++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, actual, expected);
    endtask

    task automatic expect_ev(input int kind, input int value, input int at);
        ev_t e;
        e.kind  = kind;
        e.value = value;
        e.at    = at;
        expq.push_back(e);
    endtask

    task automatic observe(input int kind, input int value);
        ev_t e;
        checks++;
        if (expq.size() == 0 || expq[0].at > cyc) begin
            $display("FAIL unexpected_%s: got value 0x%0h at edge %0d, required no event", kname[kind], value, cyc);
        end else begin
            e = expq.pop_front();
            if (e.kind == kind && e.value == value && e.at == cyc) passed++;
            else $display("FAIL event_%s: got %s 0x%0h at edge %0d, required %s 0x%0h at edge %0d",
                          kname[e.kind], kname[kind], value, cyc, kname[e.kind], e.value, e.at);
        end
    endtask

    // Monitor: turns every output change into an event and checks it against the queue
    initial begin
        logic        prev_req;
        logic        prev_rej;
        logic [24:0] prev_oh;
        logic [4:0]  prev_data;
        ev_t         e;
        prev_req  = 1'b0;
        prev_rej  = 1'b0;
        prev_oh   = 25'h1;
        prev_data = '0;
        forever begin
            @(posedge clka);
            #1;
            if (!in_reset) begin
                while (expq.size() > 0 && expq[0].at < cyc) begin
                    e = expq.pop_front();
                    checks++;
                    $display("FAIL missing_%s: got nothing by edge %0d, required value 0x%0h at edge %0d",
                             kname[e.kind], cyc, e.value, e.at);
                end
                if (req && !prev_req)       observe(K_REQ, int'(data));
                if (!req && prev_req)       observe(K_DROP, 0);
                if (reject && !prev_rej)    observe(K_REJ, 0);
                if (!reject && prev_rej)    observe(K_REJ_END, 0);
                if (cursor_onehot != prev_oh) observe(K_MOVE, int'(cursor_onehot));
                if (req && prev_req && data != prev_data) observe(K_DATA, int'(data));
            end
            prev_req  = req;
            prev_rej  = reject;
            prev_oh   = cursor_onehot;
            prev_data = data;
        end
    end

    task automatic drive(input logic [4:0] m);
        {btn_sel, btn_up, btn_down, btn_left, btn_right} = m;
    endtask

    // Press the buttons in m, hold, release and let the release settle
    task automatic tap(input logic [4:0] m, input int kind, input int value);
        int c;
        @(negedge clka);
        c = cyc;
        drive(m);
        if (kind != K_NONE) expect_ev(kind, value, c + D + 4);
        if (kind == K_REJ) expect_ev(K_REJ_END, 0, c + D + 5);
        repeat (D + 6) @(negedge clka);
        drive('0);
        repeat (D + 6) @(negedge clka);
    endtask

    task automatic pulse_ack();
        @(negedge clka);
        expect_ev(K_DROP, 0, cyc + 1);
        ack = 1'b1;
        @(negedge clka);
        ack = 1'b0;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clka);
        in_reset = 1'b1;
        restart  = 1'b1;
        #1;
        chk({tag, "_req_async"}, int'(req), 0);
        repeat (2) @(negedge clka);
        restart = 1'b0;
        @(posedge clka);
        #1;
        chk({tag, "_cursor"}, int'(cursor_onehot), 1);
        chk({tag, "_req"}, int'(req), 0);
        chk({tag, "_data"}, int'(data), 0);
        chk({tag, "_reject"}, int'(reject), 0);
        in_reset = 1'b0;
    endtask

    initial begin
        int c;

        do_reset("reset0");

        // Walk right across row 0, then down: (1,4) -> idx 9
        tap(M_RIGHT, K_MOVE, 1 << 1);
        tap(M_RIGHT, K_MOVE, 1 << 2);
        tap(M_RIGHT, K_MOVE, 1 << 3);
        tap(M_RIGHT, K_MOVE, 1 << 4);
        tap(M_DOWN,  K_MOVE, 1 << 9);
        chk("walk_onehot", int'(cursor_onehot), 32'h0000200);
        chk("walk_no_req", int'(req), 0);

        // Wrap-around from (0,0): left -> (0,4), up -> (4,4)
        do_reset("reset1");
        tap(M_LEFT, K_MOVE, 1 << 4);
        tap(M_UP,   K_MOVE, 1 << 24);
        chk("wrap_onehot", int'(cursor_onehot), 32'h1000000);

        // Select idx 7, buttons ignored while waiting, ack releases
        do_reset("reset2");
        tap(M_DOWN,  K_MOVE, 1 << 5);
        tap(M_RIGHT, K_MOVE, 1 << 6);
        tap(M_RIGHT, K_MOVE, 1 << 7);
        tap(M_SEL,   K_REQ,  7);
        tap(M_RIGHT, K_NONE, 0);
        pulse_ack();
        tap(M_RIGHT, K_MOVE, 1 << 8);

        // Select on a cleared cell
        tap(M_LEFT, K_MOVE, 1 << 7);
        cleared = 25'h0000080;
        tap(M_SEL, K_REJ, 0);
        cleared = '0;

        // Game over discards the pending request and locks the buttons
        tap(M_SEL, K_REQ, 7);
        @(negedge clka);
        expect_ev(K_DROP, 0, cyc + 1);
        gameover = 1'b1;
        tap(M_DOWN, K_NONE, 0);
        tap(M_SEL,  K_NONE, 0);
        @(negedge clka);
        gameover = 1'b0;
        repeat (2) @(negedge clka);
        tap(M_DOWN, K_MOVE, 1 << 12);

        // sel and up in the same cycle: only the request
        tap(M_SEL | M_UP, K_REQ, 12);

        // ack and a sel press land on the same edge: req drops, sel ignored
        @(negedge clka);
        c = cyc;
        drive(M_SEL);
        expect_ev(K_DROP, 0, c + D + 4);
        repeat (D + 3) @(negedge clka);
        ack = 1'b1;
        @(negedge clka);
        ack = 1'b0;
        repeat (2) @(negedge clka);
        drive('0);
        repeat (D + 6) @(negedge clka);

        // Bouncing up button never settles long enough to move
        for (int i = 0; i < 10; i++) begin
            btn_up = ~btn_up;
            repeat (2) @(negedge clka);
        end
        btn_up = 1'b0;
        repeat (D + 6) @(negedge clka);
        tap(M_UP, K_MOVE, 1 << 7);

        // Restart in the middle of a handshake
        tap(M_SEL, K_REQ, 7);
        do_reset("reset3");
        repeat (20) @(negedge clka);
        tap(M_RIGHT, K_MOVE, 1 << 1);

        // Drain anything still outstanding, bounded
        for (int i = 0; i < 50 && expq.size() > 0; i++) @(negedge clka);
        while (expq.size() > 0) begin
            ev_t e;
            e = expq.pop_front();
            checks++;
            $display("FAIL drain_%s: got nothing, required value 0x%0h at edge %0d", kname[e.kind], e.value, e.at);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cell_select_encoder.md
Name: cell_select_encoder

Overview:
- User-input front end for the minesweeper game.
- Turns five push-buttons into a cursor on the 5x5 board. On a select, it encodes the cursor cell to the 5-bit index (0..24, row*5+col) that the datapath later decodes to one-hot.
- Offers each index to the game controller over a req/ack handshake. The controller raises ack in the cycle it drives load.
- Refuses selects on already-cleared cells and ignores all input while the game is over.

Parameters:
- DEBOUNCE, 16, number of consecutive stable synchronized samples before a button level is accepted (>=2; the bench uses 4).
- GRID_DIM, 5, board side length; NCELLS = GRID_DIM*GRID_DIM = 25.

Ports:
- clka  input  1  single system clock; all flops on posedge clka.
- restart  input  1  asynchronous, active-high reset.
- btn_up  input  1  raw, asynchronous, active-high.
- btn_down  input  1  raw, asynchronous, active-high.
- btn_left  input  1  raw, asynchronous, active-high.
- btn_right  input  1  raw, asynchronous, active-high.
- btn_sel  input  1  raw, asynchronous, active-high.
- cleared  input  25  cells already cleared (bit i = index i).
- gameover  input  1  game-over flag from the datapath.
- ack  input  1  controller has consumed data (one-cycle pulse or level).
- data  output  5  encoded selected cell index.
- req  output  1  data valid, awaiting ack.
- cursor_onehot  output  25  one-hot cursor position, for display.
- reject  output  1  one-cycle pulse: select hit a cleared cell.

Behaviour:
- Reset (async assert, sync release) sets:
  - row=0, col=0, cursor_onehot=25'h1
  - data=0, req=0, reject=0
  - state=IDLE
  - all sync/debounce flops=0
- Input conditioning, per button:
  - 2-flop synchronizer, then a counter of consecutive samples differing from the debounced level.
  - The debounced level flips when the count reaches DEBOUNCE; any agreeing sample clears the counter.
  - A rising edge of the debounced level gives a one-cycle press pulse.
  - Fixed latency: a raw level held stable produces its effect (cursor move, req rise or reject pulse) exactly DEBOUNCE+3 clka edges after the first edge sampling the new level.
- Arbitration:
  - At most one action per cycle.
  - Priority: sel > up > down > left > right. Lower-priority pulses in the same cycle are dropped.
- Cursor moves, in IDLE only:
  - up: row-1; down: row+1; left: col-1; right: col+1.
  - Wrap-around: row/col 0 -1 -> 4, and 4 +1 -> 0.
  - cursor_onehot updates in the same edge as row/col.
- States:
  - IDLE:
    - sel with cleared[idx]=1 -> reject=1 for one cycle; stay IDLE.
    - sel with cleared[idx]=0 -> data<=idx, req<=1 -> WAIT_ACK.
  - WAIT_ACK:
    - req held high, data held stable.
    - All button pulses ignored, not queued.
    - ack=1 -> req<=0 -> IDLE. Buttons are accepted from the next cycle.
  - LOCKED:
    - Entered from any state when gameover=1. This takes priority over ack and select in the same cycle.
    - req<=0 at once; a pending request is discarded (data keeps its last value).
    - All pulses ignored.
    - gameover=0 -> IDLE with the cursor unchanged.
- ack and cleared are ignored outside WAIT_ACK and IDLE respectively.
- A held button produces exactly one action (no auto-repeat).
- Simultaneous ack and sel press in WAIT_ACK: req drops and the sel is ignored.
- restart mid-handshake: req drops asynchronously and no action is pending after release.
- idx arithmetic is 5-bit unsigned, row*5+col with row,col in 0..4; it is never >24.

Decomposition:
- Shared package `ms_pkg` holds:
  - GRID_DIM=5, NCELLS=25, IDX_W=5
  - state typedef {IDLE, WAIT_ACK, LOCKED}
  - a function idx_of(row,col)
  - a function onehot_of(idx); the datapath's decoder reuses it.
- Sub-module `btn_debounce` (parameter DEBOUNCE; ports clka, restart, raw -> level, press), instantiated five times.
- The top level holds arbitration, the cursor registers and the FSM.

Test Plan:
- Reset, then 4 x btn_right, then 1 x btn_down -> cursor (row1,col4), cursor_onehot=25'h0000200, no req.
- From (0,0): btn_left, then btn_up -> (0,4), then (4,4); cursor_onehot=25'h1000000.
- Cursor at idx 7, cleared=0, btn_sel -> req=1, data=7 exactly DEBOUNCE+3 edges after the press. Hold ack low 10 cycles while pressing btn_right -> data and cursor unchanged. Pulse ack -> req=0 next edge; the next btn_right then moves the cursor.
- cleared=25'h0000080, cursor idx 7, btn_sel -> reject high exactly one cycle, req stays 0.
- req pending, gameover=1 -> req=0 next edge, buttons ignored. gameover=0 -> btn_down moves the cursor normally.
- btn_sel and btn_up debounced to the same cycle -> only the request is issued, cursor unchanged. Bounce btn_up 0/1 every 2 cycles for 20 cycles -> no move.
